// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Covers FSM state encoding, frame sync byte and sticky error codes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         WORD_W        = 32;
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream intake plus IMEM write port of the loader.
// The loader side uses the slave modport; the UART/RAM side uses master.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four accepted bytes into a 32-bit word and emits a registered
// one-cycle word_valid pulse together with the packed word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              last_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] sr_shift;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_q, word_d;

  // Big-endian shifts left so the first byte ends up in [31:24];
  // little-endian shifts right so it ends up in [7:0].
  generate
    if (BIG_ENDIAN) begin : g_be
      assign sr_shift = {sr_q[23:0], byte_i};
    end else begin : g_le
      assign sr_shift = {byte_i, sr_q[31:8]};
    end
  endgenerate

  assign last_o = (idx_q == LAST_BYTE_IDX);

  always_comb begin
    idx_d        = idx_q;
    sr_d         = sr_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clear_i) begin
      idx_d = 2'd0;
      sr_d  = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 2'd1;
      sr_d  = sr_shift;
      if (last_o) begin
        word_valid_d = 1'b1;
        word_d       = sr_shift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= 2'd0;
      sr_q         <= '0;
      word_valid_q <= 1'b0;
      word_q       <= '0;
    end else begin
      idx_q        <= idx_d;
      sr_q         <= sr_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing sequential IMEM words; holds the CPU
// in reset while a frame is in flight or after a failed load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err_code,
  output logic [ADDR_W:0] words_loaded
);

  localparam int         TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chk_q, chk_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        err_q, err_d;
  logic              hold_q, hold_d;

  logic        accept;
  logic        in_frame;
  logic        pack_clear;
  logic        pack_valid;
  logic        pack_last;
  logic [15:0] n_rx;
  logic [16:0] words_next;

  assign accept     = bus.rx_valid && bus.rx_ready;
  assign in_frame   = (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK});
  assign n_rx       = {len_hi_q, bus.rx_data};
  assign words_next = 17'(words_q) + 17'd1;

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    words_d    = words_q;
    addr_d     = addr_q;
    chk_d      = chk_q;
    timer_d    = '0;
    err_d      = err_q;
    hold_d     = hold_q;
    pack_clear = 1'b0;
    pack_valid = 1'b0;

    if (in_frame && !accept) begin
      timer_d = timer_q + TMR_W'(1);
    end

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (accept && bus.rx_data == SYNC_BYTE) begin
          state_d    = ST_LEN_HI;
          err_d      = ERR_NONE;
          words_d    = '0;
          chk_d      = 8'd0;
          hold_d     = 1'b1;
          pack_clear = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = bus.rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = n_rx;
          if ({1'b0, n_rx} > MAX_N) begin
            state_d = ST_ERR;
            err_d   = ERR_LEN;
          end else if (n_rx == 16'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ bus.rx_data;
          pack_valid = 1'b1;
          // The write lands next cycle, so address and count update together.
          if (pack_last) begin
            words_d = words_q + 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            if (words_next == {1'b0, len_q}) begin
              state_d = ST_CHK;
            end
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (bus.rx_data == chk_q) begin
            state_d = ST_DONE;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = ERR_CHK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_frame && !accept && timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
      state_d = ST_ERR;
      err_d   = ERR_TIMEOUT;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_hi_q <= 8'd0;
      len_q    <= 16'd0;
      words_q  <= '0;
      addr_q   <= '0;
      chk_q    <= 8'd0;
      timer_q  <= '0;
      err_q    <= ERR_NONE;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      chk_q    <= chk_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
    end
  end

  imem_loader_byte_packer #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pack_clear),
    .byte_valid_i(pack_valid),
    .byte_i      (bus.rx_data),
    .last_o      (pack_last),
    .word_valid_o(bus.imem_we),
    .word_o      (bus.imem_wdata)
  );

  assign bus.rx_ready  = 1'b1;
  assign bus.imem_addr = addr_q;
  assign busy          = in_frame;
  assign done          = (state_q == ST_DONE);
  assign cpu_hold      = hold_q;
  assign err_code      = err_q;
  assign words_loaded  = words_q;

endmodule
